// File: rtl/inversek_2j_pkg.sv
// inversek_pkg
// Shared constants, the CORDIC arctangent table, the sequencer state type
// and the guard-bit rounding helper used by the inverse-kinematics engine.
// All angles are radians; public words are signed Q16.15, and the internal
// datapath carries two extra fraction bits (Q16.17 in 34 bits).
package inversek_pkg;

  localparam int WIDTH    = 32;          // public word width
  localparam int FRAC     = 15;          // public fraction bits
  localparam int ITER     = 16;          // CORDIC and square-root iterations
  localparam int GUARD    = 2;           // internal guard bits below Q15
  localparam int IW       = WIDTH + GUARD;

  localparam int PI       = 102944;      // pi   in Q15
  localparam int HALF_PI  = 51472;       // pi/2 in Q15
  localparam int CORDIC_K = 19898;       // 0.607253 in Q15

  // atan(2^-i) in Q15.
  localparam logic [15:0] ATAN_Q15 [ITER] = '{
    16'd25736, 16'd15193, 16'd8027, 16'd4075,
    16'd2045,  16'd1024,  16'd512,  16'd256,
    16'd128,   16'd64,    16'd32,   16'd16,
    16'd8,     16'd4,     16'd2,    16'd1
  };

  typedef enum logic [2:0] {
    LOAD,
    VEC1,
    SCALE,
    SQRT,
    VEC2,
    DONE
  } state_t;

  // Drop the guard bits with round-half-up and narrow to a public word.
  function automatic logic [WIDTH-1:0] round_guard(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] t;
    t = v + IW'(2);
    return WIDTH'(t >>> GUARD);
  endfunction

endpackage

// File: rtl/inversek_2j_cordic_vec.sv
// cordic_vec
// Iterative vectoring CORDIC. A start pulse loads (x0, y0), pre-rotated by
// +/-pi/2 when x0 < 0 so the 16 micro-rotations always converge; each of the
// following 16 cycles performs one micro-rotation driving y toward zero.
// Afterwards mag holds |(x0, y0)| / K and ang holds atan2(y0, x0), both with
// two guard bits (Q16.17), until the next start.
// Ports:
//   clock, rst  rising-edge clock, synchronous active-high reset
//   start       load x0/y0 and begin (one-cycle pulse)
//   x0, y0      input vector, Q16.17
//   done        high during the cycle that performs the final micro-rotation
//   mag, ang    unscaled magnitude and angle, Q16.17
module cordic_vec
  import inversek_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [IW-1:0] x0,
  input  logic signed [IW-1:0] y0,
  output logic                 done,
  output logic signed [IW-1:0] mag,
  output logic signed [IW-1:0] ang
);

  localparam logic signed [IW-1:0] HALF_PI_G = IW'(HALF_PI) <<< GUARD;

  logic signed [IW-1:0] xr, yr, zr;
  logic signed [IW-1:0] xs, ys, at;
  logic [3:0]           iter;
  logic                 busy;

  assign xs   = xr >>> iter;
  assign ys   = yr >>> iter;
  assign at   = {16'd0, ATAN_Q15[iter], 2'b00};
  assign done = busy && (iter == 4'(ITER - 1));
  assign mag  = xr;
  assign ang  = zr;

  // NOTE: state registers use non-blocking assignments so every register in
  // the block updates from the values present before the clock edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      xr   <= '0;
      yr   <= '0;
      zr   <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (start) begin
      iter <= '0;
      busy <= 1'b1;
      if (x0[IW-1]) begin
        // Left half-plane: rotate into the right half-plane first. y0 = 0
        // goes the -pi/2 way, so the negative x axis yields +pi.
        if (!y0[IW-1]) begin
          xr <= y0;
          yr <= -x0;
          zr <= HALF_PI_G;
        end else begin
          xr <= -y0;
          yr <= x0;
          zr <= -HALF_PI_G;
        end
      end else begin
        xr <= x0;
        yr <= y0;
        zr <= '0;
      end
    end else if (busy) begin
      if (yr[IW-1]) begin
        xr <= xr - ys;
        yr <= yr + xs;
        zr <= zr - at;
      end else begin
        xr <= xr + ys;
        yr <= yr - xs;
        zr <= zr + at;
      end
      iter <= iter + 4'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/inversek_2j.sv
// inversek_2j
// Free-running two-link (l1 = l2 = 0.5) inverse-kinematics engine. Every
// 51 cycles it samples (x, y) and produces the elbow-down joint angles:
//   theta1 = atan2(y, x) - acos(rc),  theta2 = 2 * acos(rc),  rc = min(r, 1)
// Sequence: LOAD(1) VEC1(16) SCALE(1) SQRT(16) VEC2(16) DONE(1). One CORDIC
// instance is shared by VEC1 (polar form of the target) and VEC2
// (acos(rc) as atan2(sqrt(1 - rc^2), rc)).
// Ports:
//   clock, rst      rising-edge clock, synchronous active-high reset
//   x, y            target point, signed Q16.15
//   theta1, theta2  shoulder / elbow angle in radians, signed Q16.15,
//                   updated at the end of DONE and held otherwise
module inversek_2j
  import inversek_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] theta1,
  output logic [WIDTH-1:0] theta2
);

  localparam int                    PW      = IW + 16;
  localparam logic signed [PW-1:0]  ROUND_K = PW'(1) <<< (FRAC - 1);
  localparam logic signed [IW-1:0]  ONE_G   = IW'(1) <<< (FRAC + GUARD);
  localparam logic [2*WIDTH:0]      ONE_SQ  = (2*WIDTH+1)'(1) << (2*FRAC);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic signed [WIDTH-1:0] x_q, y_q;
  logic signed [IW-1:0]    phi_q, rc_q;
  logic [WIDTH-1:0]        rad_q;
  logic [17:0]             rem_q;
  logic [15:0]             root_q;

  logic                    cv_start, cv_done;
  logic signed [IW-1:0]    cv_x0, cv_y0, cv_mag, cv_ang;

  logic signed [2*WIDTH-1:0] xx, yy;
  logic [2*WIDTH:0]          r2;
  logic                      reach;
  logic signed [PW-1:0]      mag_prod;
  logic signed [IW-1:0]      mag_k, rc_d, phi_d;
  logic [WIDTH-1:0]          rad_d;
  logic [19:0]               rem_sh, trial, rem_nxt;
  logic [15:0]               root_nxt;

  cordic_vec u_cordic (
    .clock (clock),
    .rst   (rst),
    .start (cv_start),
    .x0    (cv_x0),
    .y0    (cv_y0),
    .done  (cv_done),
    .mag   (cv_mag),
    .ang   (cv_ang)
  );

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cv_start = 1'b0;
    cv_x0    = rc_q;
    cv_y0    = {16'd0, root_nxt, 2'b00};
    unique case (state_q)
      LOAD: begin
        cv_start = 1'b1;
        cv_x0    = {x, 2'b00};
        cv_y0    = {y, 2'b00};
        state_d  = VEC1;
      end
      VEC1:  if (cv_done) state_d = SCALE;
      SCALE: state_d = SQRT;
      SQRT: begin
        // The final root bit is formed this cycle; hand it straight to the
        // CORDIC so VEC2 gets all 16 cycles for micro-rotations.
        if (cnt_q == 4'd15) begin
          cv_start = 1'b1;
          state_d  = VEC2;
        end
      end
      VEC2:    if (cv_done) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Reach test and 1 - r^2 come from the exact x^2 + y^2 rather than the
  // CORDIC magnitude: near full reach acos is ill-conditioned, and a few
  // LSB of magnitude error there would turn into a large elbow-angle error.
  assign xx       = (2*WIDTH)'(x_q) * (2*WIDTH)'(x_q);
  assign yy       = (2*WIDTH)'(y_q) * (2*WIDTH)'(y_q);
  assign r2       = {1'b0, xx} + {1'b0, yy};
  assign reach    = (r2 < ONE_SQ);
  assign rad_d    = reach ? WIDTH'(ONE_SQ - r2) : '0;
  assign mag_prod = PW'(cv_mag) * PW'(CORDIC_K);
  assign mag_k    = IW'((mag_prod + ROUND_K) >>> FRAC);
  assign phi_d    = (x_q == '0 && y_q == '0) ? '0 : cv_ang;

  always_comb begin
    if (!reach || mag_k > ONE_G) rc_d = ONE_G;
    else if (mag_k[IW-1])        rc_d = '0;
    else                         rc_d = mag_k;
  end

  // One restoring square-root step: two radicand bits in, one root bit out.
  // The radicand is (1 - r^2) in Q30, so the root is sqrt(1 - r^2) in Q15.
  always_comb begin
    rem_sh = {rem_q, rad_q[WIDTH-1 -: 2]};
    trial  = {2'b00, root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_nxt  = rem_sh - trial;
      root_nxt = {root_q[14:0], 1'b1};
    end else begin
      rem_nxt  = rem_sh;
      root_nxt = {root_q[14:0], 1'b0};
    end
  end

  // NOTE: datapath registers are cleared along with control so an aborted
  // computation leaves nothing behind; there are no memory arrays to reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      phi_q   <= '0;
      rc_q    <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      theta1  <= '0;
      theta2  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        LOAD: begin
          x_q <= x;
          y_q <= y;
        end
        SCALE: begin
          phi_q  <= phi_d;
          rc_q   <= rc_d;
          rad_q  <= rad_d;
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= '0;
        end
        SQRT: begin
          rad_q  <= rad_q << 2;
          rem_q  <= 18'(rem_nxt);
          root_q <= root_nxt;
          cnt_q  <= cnt_q + 4'd1;
        end
        DONE: begin
          theta1 <= round_guard(phi_q - cv_ang);
          theta2 <= round_guard(cv_ang <<< 1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inversek_2j.sv
// tb_inversek_2j
// Directed and random checks of the inverse-kinematics engine against a
// real-arithmetic model of the arm geometry. All sampling and driving is
// done on the falling clock edge.
module tb_inversek_2j;

  localparam int TOL     = 64;
  localparam int TWO_PI  = 205887;   // 2*pi in Q15

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] x     = '0;
  logic [31:0] y     = '0;
  logic [31:0] theta1, theta2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  inversek_2j dut (
    .clock  (clock),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .theta1 (theta1),
    .theta2 (theta2)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Compare with tolerance; angles may be compared modulo 2*pi.
  task automatic check(input string tag, input int obs, input int exp,
                       input int tol, input bit wrap);
    int d;
    bit ok;
    d = obs - exp;
    if (wrap) begin
      if (d > TWO_PI / 2)       d -= TWO_PI;
      else if (d < -TWO_PI / 2) d += TWO_PI;
    end
    ok = (d <= tol) && (d >= -tol);
    n_checks++;
    assert (ok === 1'b1)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
      end
  endtask

  task automatic check_pair(input string tag, input int e1, input int e2, input int tol);
    check({tag, "_theta1"}, theta1, e1, tol, 1'b1);
    check({tag, "_theta2"}, theta2, e2, tol, 1'b0);
  endtask

  function automatic int q15(input real v);
    return (v >= 0.0) ? $rtoi(v * 32768.0 + 0.5) : -$rtoi(-v * 32768.0 + 0.5);
  endfunction

  // Geometry of the two-link arm, l1 = l2 = 0.5, elbow-down.
  task automatic ref_ik(input int xi, input int yi, output int t1, output int t2);
    real xr, yr, r, phi, alpha;
    xr    = xi / 32768.0;
    yr    = yi / 32768.0;
    r     = $sqrt(xr * xr + yr * yr);
    phi   = (xi == 0 && yi == 0) ? 0.0 : $atan2(yr, xr);
    if (r > 1.0) r = 1.0;
    alpha = $acos(r);
    t1    = q15(phi - alpha);
    t2    = q15(2.0 * alpha);
  endtask

  function automatic bit near(input logic [31:0] obs, input int exp);
    int d;
    d = int'(obs) - exp;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  int dir_x  [6] = '{16384, 0,     -16384, 32768, 65536, 0};
  int dir_y  [6] = '{16384, 16384, 0,      0,     0,     0};
  int dir_t1 [6] = '{0,     17157, 68629,  0,     0,     -51472};
  int dir_t2 [6] = '{51472, 68629, 68629,  0,     0,     102944};

  initial begin
    int e1, e2, xi, yi, first_new, bad_before, bad_after;
    bit seen_new;

    // Reset state.
    cycles(3);
    check("reset_theta1", theta1, 0, 0, 1'b0);
    check("reset_theta2", theta2, 0, 0, 1'b0);

    // First result after release: nothing at 50 cycles, the answer at 52.
    x   = 32'd16384;
    y   = 32'd16384;
    rst = 1'b0;
    cycles(50);
    check_pair("early", 0, 0, 0);
    cycles(2);
    check_pair("first", 0, 51472, TOL);

    // Directed points, including full reach, out of reach and the origin.
    for (int i = 0; i < 6; i++) begin
      x = dir_x[i];
      y = dir_y[i];
      cycles(103);
      check_pair($sformatf("dir%0d", i), dir_t1[i], dir_t2[i], TOL);
    end

    // Hold / latency: old value until the update, new value within 102
    // cycles, then stable for at least 51 more.
    x          = 32'd16384;
    y          = 32'd16384;
    seen_new   = 1'b0;
    first_new  = 0;
    bad_before = 0;
    bad_after  = 0;
    for (int i = 1; i <= 160; i++) begin
      @(negedge clock);
      if (!seen_new && near(theta1, 0) && near(theta2, 51472)) begin
        seen_new  = 1'b1;
        first_new = i;
      end
      if (!seen_new && !(near(theta1, -51472) && near(theta2, 102944))) bad_before++;
      if (seen_new && !(near(theta1, 0) && near(theta2, 51472)))        bad_after++;
    end
    check("hold_old_value", bad_before, 0, 0, 1'b0);
    check("new_value_seen", int'(seen_new), 1, 0, 1'b0);
    check("new_within_102", int'(first_new <= 102), 1, 0, 1'b0);
    check("new_stable", bad_after, 0, 0, 1'b0);

    // Random targets against the reference model, both inside and beyond reach.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        xi = int'($urandom_range(46000)) - 23000;
        yi = int'($urandom_range(46000)) - 23000;
      end else begin
        xi = int'($urandom_range(80000)) - 40000;
        yi = int'($urandom_range(80000)) - 40000;
      end
      x = xi;
      y = yi;
      cycles(103);
      ref_ik(xi, yi, e1, e2);
      check_pair($sformatf("rand%0d_x%0d_y%0d", i, xi, yi), e1, e2, TOL);
    end

    // Reset in the middle of VEC2 of the second computation after release.
    x   = 32'd0;
    y   = 32'd16384;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(92);
    check_pair("pre_abort", 17157, 68629, TOL);
    rst = 1'b1;
    cycles(1);
    check_pair("abort", 0, 0, 0);
    rst = 1'b0;
    cycles(50);
    check_pair("abort_early", 0, 0, 0);
    cycles(2);
    check_pair("abort_first", 17157, 68629, TOL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
